// File: rtl/pixgen_ext_if.sv
// pixgen_ext_if: readout, font-ROM and colour signals of the text-mode pixel generator.
// The master side drives readout/ROM data; the slave (generator) returns address, pixel and colour.
interface pixgen_ext_if #(
  parameter int ROW_BITS = 4
);
  logic [7:0]          readoutData;
  logic [3:0]          readoutCount;
  logic                active;
  logic                nVis;
  logic [ROW_BITS-1:0] vCount;
  logic                frameTick;
  logic                blinkMode;
  logic                cursorEn;
  logic                cursorHit;
  logic [ROW_BITS-1:0] cursorStart;
  logic [ROW_BITS-1:0] cursorEnd;
  logic [7+ROW_BITS:0] fontRdAddr;
  logic [7:0]          fontRdData;
  logic                pixel;
  logic [3:0]          rgbi;

  modport master (
    output readoutData, readoutCount, active, nVis, vCount, frameTick,
           blinkMode, cursorEn, cursorHit, cursorStart, cursorEnd, fontRdData,
    input  fontRdAddr, pixel, rgbi
  );

  modport slave (
    input  readoutData, readoutCount, active, nVis, vCount, frameTick,
           blinkMode, cursorEn, cursorHit, cursorStart, cursorEnd, fontRdData,
    output fontRdAddr, pixel, rgbi
  );
endinterface

// File: rtl/pixgen_ext.sv
// pixgen_ext: serialises glyph rows from an external font ROM and resolves RGBI with blink and cursor.
// rgbi lags pixel by one clk; no backpressure, the readout cadence is free-running.
module pixgen_ext #(
  parameter int CHAR_W     = 8,
  parameter int ROW_BITS   = 4,
  parameter int CHAR_LD    = 3,
  parameter int LINE_GFX   = 1,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        nrst,
  pixgen_ext_if.slave bus
);
  localparam logic [3:0] LD_CNT   = 4'(CHAR_LD);
  localparam logic [3:0] LAST_CNT = 4'(CHAR_W - 1);

  logic [7:0]            charReg;
  logic [7:0]            attrReg;
  logic [CHAR_W-1:0]     shiftReg;
  logic [CHAR_W-1:0]     loadVal;
  logic                  cursorReg;
  logic [BLINK_LOG2-1:0] frameCnt;
  logic [3:0]            rgbiReg;
  logic                  charLoad;
  logic                  rowLoad;
  logic                  doShift;
  logic                  blinkPh;
  logic                  curPh;
  logic                  cursorRow;
  logic                  pEff;
  logic [3:0]            fg;
  logic [3:0]            bg;

  assign charLoad = bus.active && (bus.readoutCount == LD_CNT);
  assign rowLoad  = bus.active && (bus.readoutCount == LAST_CNT);
  assign doShift  = !bus.nVis && (bus.readoutCount != LAST_CNT);

  assign bus.fontRdAddr = {charReg, bus.vCount};
  assign bus.pixel      = shiftReg[CHAR_W-1];
  assign bus.rgbi       = rgbiReg;

  // 9-wide cells repeat bit 0 of line-graphics glyphs so box drawing stays continuous.
  always_comb begin
    loadVal = '0;
    loadVal[CHAR_W-1 -: 8] = bus.fontRdData;
    if (CHAR_W == 9 && LINE_GFX != 0 && charReg[7:5] == 3'b110)
      loadVal[0] = bus.fontRdData[0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      charReg   <= '0;
      attrReg   <= '0;
      shiftReg  <= '0;
      cursorReg <= 1'b0;
    end else begin
      if (charLoad) begin
        charReg   <= bus.readoutData;
        cursorReg <= bus.cursorHit;
      end
      if (rowLoad) begin
        attrReg  <= bus.readoutData;
        shiftReg <= loadVal;
      end else if (doShift) begin
        shiftReg <= {shiftReg[CHAR_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      frameCnt <= '0;
    else if (bus.frameTick)
      frameCnt <= frameCnt + 1'b1;
  end

  // Cursor toggles at twice the attribute blink rate.
  assign blinkPh   = frameCnt[BLINK_LOG2-1];
  assign curPh     = frameCnt[BLINK_LOG2-2];
  assign cursorRow = (bus.cursorStart <= bus.vCount) && (bus.vCount <= bus.cursorEnd);

  assign fg = attrReg[3:0];
  assign bg = bus.blinkMode ? {1'b0, attrReg[6:4]} : attrReg[7:4];

  always_comb begin
    pEff = shiftReg[CHAR_W-1];
    if (bus.blinkMode && attrReg[7] && blinkPh)
      pEff = 1'b0;
    if (bus.cursorEn && cursorReg && cursorRow && curPh)
      pEff = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      rgbiReg <= 4'h0;
    else
      rgbiReg <= bus.nVis ? 4'h0 : (pEff ? fg : bg);
  end
endmodule

// File: tb/tb_pixgen_ext.sv
// Bench for pixgen_ext: 8-wide and 9-wide instances against a cell-level model with a font ROM.
module tb_pixgen_ext;
  localparam int RB    = 4;
  localparam int CH_LD = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  logic [7:0] rdData;
  logic [3:0] rdCount;
  logic       act, nv, ft;
  logic [RB-1:0] vRow;
  logic       blinkMode, cursorEn, cursorHit;
  logic [RB-1:0] cursorStart, cursorEnd;
  logic [7:0] rom [4096];
  logic [7:0] rom8Q, rom9Q;

  pixgen_ext_if #(.ROW_BITS(RB)) bus8 ();
  pixgen_ext_if #(.ROW_BITS(RB)) bus9 ();

  pixgen_ext #(.CHAR_W(8), .ROW_BITS(RB)) dut8 (.clk(clk), .nrst(nrst), .bus(bus8.slave));
  pixgen_ext #(.CHAR_W(9), .ROW_BITS(RB)) dut9 (.clk(clk), .nrst(nrst), .bus(bus9.slave));

  // The idle instance sees no activity and a blanked display.
  assign bus8.readoutData  = rdData;
  assign bus8.readoutCount = rdCount;
  assign bus8.active       = act && !sel;
  assign bus8.nVis         = nv || sel;
  assign bus8.vCount       = vRow;
  assign bus8.frameTick    = ft && !sel;
  assign bus8.blinkMode    = blinkMode;
  assign bus8.cursorEn     = cursorEn;
  assign bus8.cursorHit    = cursorHit;
  assign bus8.cursorStart  = cursorStart;
  assign bus8.cursorEnd    = cursorEnd;
  assign bus8.fontRdData   = rom8Q;

  assign bus9.readoutData  = rdData;
  assign bus9.readoutCount = rdCount;
  assign bus9.active       = act && sel;
  assign bus9.nVis         = nv || !sel;
  assign bus9.vCount       = vRow;
  assign bus9.frameTick    = ft && sel;
  assign bus9.blinkMode    = blinkMode;
  assign bus9.cursorEn     = cursorEn;
  assign bus9.cursorHit    = cursorHit;
  assign bus9.cursorStart  = cursorStart;
  assign bus9.cursorEnd    = cursorEnd;
  assign bus9.fontRdData   = rom9Q;

  always @(posedge clk) begin
    rom8Q <= rom[bus8.fontRdAddr];
    rom9Q <= rom[bus9.fontRdAddr];
  end

  int nChecks, nPass;

  // Model: latched char/attr, the loaded glyph row and which bit of it is on screen.
  logic [7:0]  mChar, mAttr;
  logic        mCur;
  int          mFrames;
  logic [8:0]  mGlyph;
  int          mPos;
  logic [11:0] mPrevAddr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (unit W=%0d, t=%0t)", tag, got, exp, sel ? 9 : 8, $time);
  endtask

  function automatic logic expPixel();
    return (mPos >= 0) ? mGlyph[mPos] : 1'b0;
  endfunction

  task automatic resetModel();
    mChar = 8'h00; mAttr = 8'h00; mCur = 1'b0; mFrames = 0;
    mGlyph = 9'h000; mPos = -1; mPrevAddr = {8'h00, vRow};
  endtask

  task automatic cycle(input int cnt, input logic [7:0] data, input logic nvIn,
                       input logic ftIn, input logic actIn);
    int w;
    logic p;
    logic [3:0] fg, bg, expRgbi;
    logic [7:0] oldChar, loadByte;
    w = sel ? 9 : 8;
    rdCount = 4'(cnt); rdData = data; nv = nvIn; ft = ftIn; act = actIn;
    #1;
    chk("fontRdAddr", 16'(sel ? bus9.fontRdAddr : bus8.fontRdAddr), 16'({mChar, vRow}));
    p = expPixel();
    if (blinkMode && mAttr[7] && mFrames >= 16) p = 1'b0;
    if (cursorEn && mCur && cursorStart <= vRow && vRow <= cursorEnd && ((mFrames / 8) % 2) == 1) p = 1'b1;
    fg = mAttr[3:0];
    bg = blinkMode ? {1'b0, mAttr[6:4]} : mAttr[7:4];
    expRgbi = nvIn ? 4'h0 : (p ? fg : bg);
    @(posedge clk); #1;
    oldChar = mChar;
    loadByte = rom[mPrevAddr];
    mPrevAddr = {oldChar, vRow};
    if (actIn && cnt == CH_LD) begin
      mChar = data;
      mCur = cursorHit;
    end
    if (actIn && cnt == w - 1) begin
      mAttr = data;
      if (w == 9) mGlyph = {loadByte, (oldChar[7:5] == 3'b110) ? loadByte[0] : 1'b0};
      else        mGlyph = {1'b0, loadByte};
      mPos = w - 1;
    end else if (!nvIn && cnt != w - 1 && mPos >= 0) begin
      mPos--;
    end
    if (ftIn) mFrames = (mFrames + 1) % 32;
    chk("pixel", 16'(sel ? bus9.pixel : bus8.pixel), 16'(expPixel()));
    chk("rgbi", 16'(sel ? bus9.rgbi : bus8.rgbi), 16'(expRgbi));
  endtask

  // nvMode: 0 visible, 1 blanked, 2 random blanking per pixel.
  task automatic runCell(input logic [7:0] c, input logic [7:0] a, input int nvMode, input logic tick);
    int w;
    logic [7:0] d;
    logic v;
    w = sel ? 9 : 8;
    for (int j = 0; j < w; j++) begin
      d = (j == CH_LD) ? c : (j == w - 1) ? a : 8'($urandom);
      v = (nvMode == 0) ? 1'b0 : (nvMode == 1) ? 1'b1 : ($urandom_range(3) == 0);
      cycle(j, d, v, tick && (j == 0), 1'b1);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cycle(0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulseReset();
    nrst = 1'b0;
    #1;
    resetModel();
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic randomCells(input int n);
    logic [7:0] c;
    for (int k = 0; k < n; k++) begin
      blinkMode   = 1'($urandom);
      cursorEn    = 1'($urandom);
      cursorHit   = 1'($urandom);
      cursorStart = RB'($urandom);
      cursorEnd   = RB'($urandom);
      vRow        = RB'($urandom);
      c = 8'($urandom);
      if ($urandom_range(1) == 0) c = {3'b110, c[4:0]};
      runCell(c, 8'($urandom), 2, 1'($urandom));
    end
  endtask

  initial begin
    nChecks = 0; nPass = 0;
    sel = 1'b0; rdData = 8'h00; rdCount = 4'h0; act = 1'b0; nv = 1'b1; ft = 1'b0;
    vRow = '0; blinkMode = 1'b0; cursorEn = 1'b0; cursorHit = 1'b0;
    cursorStart = '0; cursorEnd = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[{8'h41, 4'd5}] = 8'hA5;
    rom[{8'h41, 4'd6}] = 8'hFF;
    rom[{8'hC4, 4'd6}] = 8'hFF;
    for (int r = 13; r < 16; r++) rom[{8'h20, 4'(r)}] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst rgbi8", 16'(bus8.rgbi), 16'h0);
    chk("rst pixel8", 16'(bus8.pixel), 16'h0);
    chk("rst rgbi9", 16'(bus9.rgbi), 16'h0);
    chk("rst pixel9", 16'(bus9.pixel), 16'h0);
    chk("rst addr8", 16'(bus8.fontRdAddr), 16'h0);
    resetModel();
    nrst = 1'b1;

    // 8-wide: glyph A5 with attr 1E, then blanked loads.
    vRow = 4'd5;
    runCell(8'h41, 8'h1E, 0, 1'b0);
    runCell(8'h41, 8'h1E, 0, 1'b0);
    runCell(8'h41, 8'h1E, 1, 1'b0);
    runCell(8'h41, 8'h1E, 1, 1'b0);
    runCell(8'h41, 8'h1E, 0, 1'b0);

    // Attribute blink: off-phase after 16 frames, glyph back after wrap at 32.
    blinkMode = 1'b1;
    runCell(8'h41, 8'h9F, 0, 1'b0);
    ticks(16);
    runCell(8'h41, 8'h9F, 0, 1'b0);
    runCell(8'h41, 8'h9F, 0, 1'b0);
    ticks(16);
    runCell(8'h41, 8'h9F, 0, 1'b0);
    runCell(8'h41, 8'h9F, 0, 1'b0);

    // Cursor on rows 14-15, then an inverted (empty) range.
    blinkMode = 1'b0; cursorEn = 1'b1; cursorHit = 1'b1;
    cursorStart = 4'd14; cursorEnd = 4'd15;
    ticks(8);
    for (int r = 13; r < 16; r++) begin
      vRow = 4'(r);
      runCell(8'h20, 8'h07, 0, 1'b0);
      runCell(8'h20, 8'h07, 0, 1'b0);
    end
    cursorStart = 4'd15; cursorEnd = 4'd14; vRow = 4'd14;
    runCell(8'h20, 8'h07, 0, 1'b0);
    runCell(8'h20, 8'h07, 0, 1'b0);

    // Reset mid-cell after a load, then recovery.
    cursorEn = 1'b0; cursorHit = 1'b0; vRow = 4'd5;
    runCell(8'h41, 8'h1E, 0, 1'b0);
    for (int j = 0; j < 3; j++) cycle(j, 8'h41, 1'b0, 1'b0, 1'b1);
    nrst = 1'b0;
    #1;
    chk("midrst rgbi", 16'(bus8.rgbi), 16'h0);
    chk("midrst pixel", 16'(bus8.pixel), 16'h0);
    resetModel();
    @(posedge clk); #1;
    nrst = 1'b1;
    runCell(8'h41, 8'h1E, 0, 1'b0);
    runCell(8'h41, 8'h1E, 0, 1'b0);
    randomCells(40);

    // 9-wide: line-graphics duplication versus an ordinary character.
    sel = 1'b1;
    blinkMode = 1'b0; cursorEn = 1'b0; cursorHit = 1'b0; vRow = 4'd6;
    pulseReset();
    runCell(8'hC4, 8'h07, 0, 1'b0);
    runCell(8'hC4, 8'h07, 0, 1'b0);
    runCell(8'h41, 8'h07, 0, 1'b0);
    runCell(8'h41, 8'h07, 0, 1'b0);
    randomCells(40);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pixgen_ext.md
Name: pixgen_ext

Overview:
- Parametrised successor to the text-mode pixel generator.
- Latches character/attribute bytes from the readout module and fetches the glyph row from an external synchronous font ROM.
- Serialises glyph rows of 8 or 9 pixels per cell and resolves a registered 4-bit RGBI colour.
- Adds attribute blink mode, 9th-column line-graphics duplication and a hardware cursor.

Parameters:
- CHAR_W, 8, pixels per cell (8 or 9); readoutCount runs 0..CHAR_W-1.
- ROW_BITS, 4, glyph row address bits (font height 2^ROW_BITS).
- CHAR_LD, 3, readoutCount value at which readoutData is the character byte.
- LINE_GFX, 1, enables 9th-column duplication for chars 0xC0-0xDF (only meaningful when CHAR_W=9).
- BLINK_LOG2, 5, frame-counter width; attribute blink period 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock
- nrst  in  1  asynchronous active-low reset
- readoutData  in  8  char/attr byte from the readout module
- readoutCount  in  4  cell phase from the readout module
- active  in  1  readout activity
- nVis  in  1  active-low visible region
- vCount  in  ROW_BITS  glyph row
- frameTick  in  1  one-cycle pulse per frame
- blinkMode  in  1  1: attr bit7 = blink; 0: attr bit7 = bg intensity
- cursorEn  in  1  cursor enable
- cursorHit  in  1  current cell is the cursor cell; sampled with the character byte
- cursorStart  in  ROW_BITS  first cursor row
- cursorEnd  in  ROW_BITS  last cursor row
- fontRdAddr  out  8+ROW_BITS  {charReg, vCount}
- fontRdData  in  8  glyph row, valid one clk after the address
- pixel  out  1  raw serial pixel (shiftReg MSB)
- rgbi  out  4  resolved colour {I,B,G,R}; registered

Behaviour:
- Reset (asynchronous on nrst low): charReg, attrReg, shiftReg, cursorReg, frameCnt, rgbi, pixel all 0. Reset has priority mid-cell; the first load after release occurs at the next qualifying readoutCount.
- fontRdAddr is combinational from charReg and vCount.
- active && readoutCount==CHAR_LD: charReg<=readoutData; cursorReg<=cursorHit.
- active && readoutCount==CHAR_W-1:
  - attrReg<=readoutData.
  - shiftReg[CHAR_W-1 -: 8]<=fontRdData.
  - If CHAR_W=9, shiftReg[0]<=(LINE_GFX && charReg[7:5]==3'b110) ? fontRdData[0] : 0.
- ~nVis && readoutCount!=CHAR_W-1: shiftReg<<=1, zero fill. A load in the same cycle as a shift condition: the load wins (the shift condition is already false at CHAR_W-1).
- Loads occur regardless of nVis; shifts occur regardless of active.
- pixel = shiftReg[CHAR_W-1].
- frameCnt (BLINK_LOG2 bits) increments on frameTick and wraps modulo 2^BLINK_LOG2.
  - blinkPh = frameCnt[BLINK_LOG2-1].
  - curPh = frameCnt[BLINK_LOG2-2] (cursor blinks at twice the attribute rate).
- Colour fields: fg = attrReg[3:0]. bg = blinkMode ? {0,attrReg[6:4]} : attrReg[7:4].
- Effective pixel p, applied in priority order:
  - p = pixel.
  - If blinkMode && attrReg[7] && blinkPh: p=0.
  - If cursorEn && cursorReg && cursorStart<=vCount<=cursorEnd && curPh: p=1.
  - If cursorStart>cursorEnd, no cursor rows are drawn.
- rgbi registered every clk: nVis ? 4'b0000 : (p ? fg : bg). Latency: rgbi reflects pixel one clk later.
- The cursor and blink terms above are evaluated in the same cycle as pixel, before the rgbi register.

Test Plan:
- CHAR_W=8, char 0x41, attr 0x1E, font row 0xA5, nVis=0 -> pixel sequence 1,0,1,0,0,1,0,1 over cells; rgbi alternates 0xE/0x1 one clk later.
- nVis=1 during load and shift -> shiftReg still loads 0xA5 but does not shift; rgbi=0.
- CHAR_W=9, char 0xC4, font 0xFF -> 9 consecutive pixels =1. Char 0x41, font 0xFF -> 9th pixel =0.
- blinkMode=1, attr 0x9F, 16 frameTicks (BLINK_LOG2=5) -> blinkPh=1, rgbi=bg 0x1 for all pixels. At 32 ticks the counter wraps, glyph reappears.
- cursorEn=1, cursorHit=1, rows 14-15, font 0x00, attr 0x07, curPh=1 -> rows 14/15 give rgbi=0x7 for every pixel; row 13 gives rgbi=0x0. cursorStart=15, cursorEnd=14 -> no cursor drawn.
- Assert nrst mid-cell after load -> rgbi, pixel, attrReg immediately 0. Release -> the next load at readoutCount=CHAR_W-1 restores output.
